// File: rtl/obi_seq_mgr_pkg.sv
// Shared types and constants for the OBI sequence manager.
package obi_seq_mgr_pkg;

  localparam int unsigned ErrCntW = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/soc_obi_pkg.sv
// SoC-level OBI channel types shared by crossbar managers and subordinates.
package soc_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/obi_seq_mgr.sv
// OBI manager that fills a word region with seed+i and optionally reads it back
// and counts mismatches. One outstanding transaction at a time.
//
// state  | meaning
// IDLE   | waiting for start_i, results held
// WR_REQ | write request for word i on the bus, waiting for gnt
// WR_RSP | write granted, waiting for rvalid
// RD_REQ | read request for word i on the bus, waiting for gnt
// RD_RSP | read granted, waiting for rvalid to compare rdata
// DONE   | one-cycle completion pulse
module obi_seq_mgr
  import soc_obi_pkg::*;
  import obi_seq_mgr_pkg::*;
#(
  parameter int unsigned MaxLen = 1024,
  parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [31:0]        base_addr_i,
  input  logic [LenW-1:0]    len_i,
  input  logic [31:0]        seed_i,
  input  logic               verify_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic [31:0]        first_err_addr_o,
  output mgr_obi_req_t       obi_req_o,
  input  mgr_obi_rsp_t       obi_rsp_i
);

  seq_state_e         state_q, state_d;
  logic [LenW-1:0]    idx_q, idx_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        seed_q, seed_d;
  logic               verify_q, verify_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]        first_err_q, first_err_d;

  logic [LenW-1:0]    idx_inc;
  logic               is_last;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_data;

  // The response error bit and the sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{obi_rsp_i.r.err, base_addr_i[1:0]};

  assign idx_inc  = idx_q + LenW'(1);
  assign is_last  = (idx_inc == len_q);
  assign cur_addr = base_q + 32'({idx_q, 2'b00});
  assign cur_data = seed_q + 32'(idx_q);

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    seed_d      = seed_q;
    verify_d    = verify_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    obi_req_o   = '0;
    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d      = {base_addr_i[31:2], 2'b00};
          len_d       = len_i;
          seed_d      = seed_i;
          verify_d    = verify_i;
          idx_d       = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          state_d     = (len_i == '0) ? DONE : WR_REQ;
        end
      end

      WR_REQ: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.we    = 1'b1;
        obi_req_o.a.be    = 4'hF;
        obi_req_o.a.addr  = cur_addr;
        obi_req_o.a.wdata = cur_data;
        if (obi_rsp_i.gnt) state_d = WR_RSP;
      end

      WR_RSP: begin
        if (obi_rsp_i.rvalid) begin
          if (is_last) begin
            if (verify_q) begin
              idx_d   = '0;
              state_d = RD_REQ;
            end else begin
              idx_d   = idx_inc;
              state_d = DONE;
            end
          end else begin
            idx_d   = idx_inc;
            state_d = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        obi_req_o.req    = 1'b1;
        obi_req_o.a.be   = 4'hF;
        obi_req_o.a.addr = cur_addr;
        if (obi_rsp_i.gnt) state_d = RD_RSP;
      end

      RD_RSP: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.rdata != cur_data) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrCntW'(1);
            if (err_cnt_q == '0) first_err_d = cur_addr;
          end
          idx_d   = idx_inc;
          state_d = is_last ? DONE : RD_REQ;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      verify_q    <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      verify_q    <= verify_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

endmodule

// File: tb/tb_obi_seq_mgr.sv
// Bench for obi_seq_mgr: table of run configurations against a memory-backed
// subordinate with a transaction scoreboard, plus reset and restart sequences.
module tb_obi_seq_mgr;
  import soc_obi_pkg::*;

  localparam int unsigned MaxLen = 1024;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  typedef struct {
    logic [31:0]     base;
    logic [LenW-1:0] len;
    logic [31:0]     seed;
    logic            verify;
    int              max_wait;
    logic [31:0]     mask;
    logic            timing;
    logic [15:0]     exp_err;
    logic [31:0]     exp_first;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic            clk;
  logic            rst_i;
  logic            start_i;
  logic [31:0]     base_addr_i;
  logic [LenW-1:0] len_i;
  logic [31:0]     seed_i;
  logic            verify_i;
  logic            busy_o;
  logic            done_o;
  logic [15:0]     err_cnt_o;
  logic [31:0]     first_err_addr_o;
  mgr_obi_req_t    obi_req;
  mgr_obi_rsp_t    obi_rsp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  txn_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cur_base;
  logic [31:0] cur_mask;
  int          max_wait;
  bit          timing_on;
  bit          have_prev_req;
  bit          pending;
  int          prev_req_cyc;
  int          last_rvalid_cyc;
  int          n_wr;
  int          n_rd;

  obi_seq_mgr #(.MaxLen(MaxLen)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .len_i            (len_i),
    .seed_i           (seed_i),
    .verify_i         (verify_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .obi_req_o        (obi_req),
    .obi_rsp_i        (obi_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] base, input int len, input logic [31:0] seed,
                              input logic verify, input int mw, input logic [31:0] mask,
                              input logic timing, input logic [15:0] e_err, input logic [31:0] e_first);
    vec_t v;
    v.base      = base;
    v.len       = LenW'(len);
    v.seed      = seed;
    v.verify    = verify;
    v.max_wait  = mw;
    v.mask      = mask;
    v.timing    = timing;
    v.exp_err   = e_err;
    v.exp_first = e_first;
    return v;
  endfunction

  // Subordinate: random grant/response delays, memory backing, scoreboard pop
  // on every grant, optional corruption of read data for masked word indices.
  initial begin : subordinate
    bit              in_req;
    int              gwait;
    int              rwait;
    mgr_obi_a_chan_t held;
    logic [31:0]     rd;
    logic [31:0]     wofs;
    txn_t            exp;
    in_req  = 1'b0;
    gwait   = 0;
    rwait   = 0;
    rd      = '0;
    obi_rsp = '0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      obi_rsp.gnt    = 1'b0;
      obi_rsp.rvalid = 1'b0;
      if (rst_i) begin
        pending = 1'b0;
        in_req  = 1'b0;
      end else if (pending) begin
        if (rwait > 0) begin
          rwait--;
        end else begin
          obi_rsp.rvalid  = 1'b1;
          obi_rsp.r.rdata = rd;
          pending         = 1'b0;
          last_rvalid_cyc = cyc;
        end
      end else if (obi_req.req) begin
        if (!in_req) begin
          in_req = 1'b1;
          held   = obi_req.a;
          gwait  = int'($urandom_range(max_wait, 0));
          if (timing_on && have_prev_req) check_eq("req_spacing", 32'(cyc - prev_req_cyc), 32'd2);
          have_prev_req = 1'b1;
          prev_req_cyc  = cyc;
        end else begin
          check_eq("a_stable_addr", obi_req.a.addr, held.addr);
          check_eq("a_stable_wdata", obi_req.a.wdata, held.wdata);
          check_eq("a_stable_we", 32'(obi_req.a.we), 32'(held.we));
        end
        if (gwait > 0) begin
          gwait--;
        end else begin
          obi_rsp.gnt = 1'b1;
          in_req      = 1'b0;
          pending     = 1'b1;
          rwait       = int'($urandom_range(max_wait, 0));
          check_eq("be", 32'(obi_req.a.be), 32'hF);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: addr 0x%08h we %0d issued, required no request",
                     obi_req.a.addr, obi_req.a.we);
          end else begin
            exp = sb.pop_front();
            check_eq("txn_we", 32'(obi_req.a.we), 32'(exp.we));
            check_eq("txn_addr", obi_req.a.addr, exp.addr);
            if (exp.we) check_eq("txn_wdata", obi_req.a.wdata, exp.data);
          end
          if (obi_req.a.we) begin
            mem[obi_req.a.addr] = obi_req.a.wdata;
            n_wr++;
            rd = '0;
          end else begin
            n_rd++;
            rd   = mem.exists(obi_req.a.addr) ? mem[obi_req.a.addr] : 32'h0;
            wofs = (obi_req.a.addr - cur_base) >> 2;
            if (wofs < 32 && cur_mask[wofs[4:0]]) rd = rd ^ 32'h0000_0100;
          end
        end
      end
    end
  end

  task automatic start_vec(input vec_t v, output int start_cyc);
    logic [31:0] b;
    b = {v.base[31:2], 2'b00};
    sb.delete();
    n_wr          = 0;
    n_rd          = 0;
    cur_base      = b;
    cur_mask      = v.mask;
    max_wait      = v.max_wait;
    timing_on     = v.timing;
    have_prev_req = 1'b0;
    for (int k = 0; k < int'(v.len); k++)
      sb.push_back('{we: 1'b1, addr: b + 32'(k * 4), data: v.seed + 32'(k)});
    if (v.verify)
      for (int k = 0; k < int'(v.len); k++)
        sb.push_back('{we: 1'b0, addr: b + 32'(k * 4), data: v.seed + 32'(k)});
    base_addr_i = v.base;
    len_i       = v.len;
    seed_i      = v.seed;
    verify_i    = v.verify;
    start_i     = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int mid_at);
    int start_cyc;
    int done_cyc;
    bit seen;
    seen     = 1'b0;
    done_cyc = 0;
    start_vec(v, start_cyc);
    for (int t = 0; t < 3000; t++) begin
      if (done_o) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (mid_at > 0 && t == mid_at) begin
        start_i     = 1'b1;
        base_addr_i = 32'hDEAD_0000;
        len_i       = LenW'(2);
        seed_i      = 32'h0;
        verify_i    = 1'b0;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("busy_at_done", 32'(busy_o), 32'd1);
      check_eq("err_cnt", 32'(err_cnt_o), 32'(v.exp_err));
      check_eq("first_err_addr", first_err_addr_o, v.exp_first);
      check_eq("n_writes", 32'(n_wr), 32'(v.len));
      check_eq("n_reads", 32'(n_rd), v.verify ? 32'(v.len) : 32'd0);
      check_eq("sb_left", 32'(sb.size()), 32'd0);
      if (v.len == '0) check_eq("done_latency_len0", 32'(done_cyc - start_cyc), 32'd1);
      else if (v.timing) check_eq("done_after_rvalid", 32'(done_cyc - last_rvalid_cyc), 32'd1);
      @(negedge clk);
      check_eq("done_pulse_end", 32'(done_o), 32'd0);
      check_eq("busy_after_done", 32'(busy_o), 32'd0);
      check_eq("err_cnt_hold", 32'(err_cnt_o), 32'(v.exp_err));
    end
  endtask

  initial begin : main
    vec_t vecs[8];
    vec_t v;
    int   sc;
    bit   got;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    seed_i      = '0;
    verify_i    = 1'b0;
    max_wait    = 0;
    cur_base    = '0;
    cur_mask    = '0;
    timing_on   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", 32'(obi_req.req), 32'd0);
    check_eq("rst_a", obi_req.a.addr | obi_req.a.wdata | 32'(obi_req.a.be) | 32'(obi_req.a.we), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    check_eq("rst_first_err", first_err_addr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    //              base           len seed           vfy wait mask    tim err first
    vecs[0] = mk(32'h1000_0000, 4, 32'hA5A5_0000, 0, 0, 32'h0,  1, 0, 32'h0);
    vecs[1] = mk(32'h3000_0000, 8, 32'h1234_5678, 1, 5, 32'h0,  0, 0, 32'h0);
    vecs[2] = mk(32'h0000_2000, 8, 32'hDEAD_0000, 1, 5, 32'h28, 0, 2, 32'h0000_200C);
    vecs[3] = mk(32'h0000_4000, 0, 32'h0000_0001, 1, 0, 32'h0,  1, 0, 32'h0);
    vecs[4] = mk(32'hFFFF_FFF8, 3, 32'h0000_0007, 1, 2, 32'h0,  0, 0, 32'h0);
    vecs[5] = mk(32'h0000_0040, 3, 32'hFFFF_FFFF, 1, 0, 32'h0,  1, 0, 32'h0);
    vecs[6] = mk(32'h0000_0103, 2, 32'h0000_0055, 1, 1, 32'h1,  0, 1, 32'h0000_0100);
    vecs[7] = mk(32'h0000_8000, 5, 32'h0000_0000, 1, 0, 32'h11, 1, 2, 32'h0000_8000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

    // Reset while a write response is pending.
    v = mk(32'h0000_6000, 4, 32'h0000_003C, 0, 5, 32'h0, 0, 0, 32'h0);
    start_vec(v, sc);
    got = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (pending && !obi_req.req && busy_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reached_wr_rsp", 32'(got), 32'd1);
    check_eq("busy_before_rst", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_req", 32'(obi_req.req), 32'd0);
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_done", 32'(done_o), 32'd0);
    check_eq("midrst_err_cnt", 32'(err_cnt_o), 32'd0);
    check_eq("midrst_first_err", first_err_addr_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk);
    run_vec(mk(32'h0000_7000, 3, 32'h0000_0099, 1, 1, 32'h4, 0, 1, 32'h0000_7008), 0);

    // Second start pulse during a run must be ignored.
    run_vec(mk(32'h0000_5000, 6, 32'h0000_0100, 1, 2, 32'h0, 0, 0, 32'h0), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
